// File: rtl/conware_frame_stats_pkg.sv
// Shared definitions for the conware frame-statistics stage: default sizes,
// skid-buffer state encoding and the cell popcount helper.
package conware_pkg;

  localparam int CONWARE_DATA_WIDTH      = 32;
  localparam int CONWARE_WORDS_PER_FRAME = 32;
  localparam int CONWARE_POP_WIDTH       = 11;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  // Number of live cells in one board word.
  function automatic logic [CONWARE_POP_WIDTH-1:0] popcount(
    input logic [CONWARE_DATA_WIDTH-1:0] word
  );
    logic [CONWARE_POP_WIDTH-1:0] cnt;
    cnt = {CONWARE_POP_WIDTH{1'b0}};
    for (int i = 0; i < CONWARE_DATA_WIDTH; i++) begin
      cnt = cnt + {{(CONWARE_POP_WIDTH-1){1'b0}}, word[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/conware_frame_stats_if.sv
// AXI4-Stream bundle used for the board stream on both sides of the stage.
interface conware_frame_stats_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic [DATA_WIDTH-1:0]   TDATA;
  logic                    TVALID;
  logic                    TLAST;
  logic                    TREADY;
  logic [DATA_WIDTH/8-1:0] TKEEP;
  logic [DATA_WIDTH/8-1:0] TSTRB;

  modport master (
    output TDATA, TVALID, TLAST, TKEEP, TSTRB,
    input  TREADY
  );

  modport slave (
    input  TDATA, TVALID, TLAST,
    output TREADY
  );

endinterface

// File: rtl/conware_axis_skid.sv
// Two-entry registered skid buffer: main output register plus one skid slot,
// with a registered upstream ready so the sink stall never reaches it combinationally.
module conware_axis_skid
  import conware_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  skid_state_e      state_r;
  skid_state_e      state_s;
  logic [WIDTH-1:0] main_r;
  logic [WIDTH-1:0] skid_r;
  logic             ready_r;
  logic             valid_r;
  logic             in_beat_s;
  logic             out_beat_s;
  logic             load_main_in_s;
  logic             load_main_skid_s;
  logic             load_skid_s;

  assign in_beat_s  = in_valid & ready_r;
  assign out_beat_s = valid_r & out_ready;

  // Next state and register load selects.
  always_comb begin
    state_s          = state_r;
    load_main_in_s   = 1'b0;
    load_main_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    case (state_r)
      EMPTY: begin
        if (in_beat_s) begin
          state_s        = ONE;
          load_main_in_s = 1'b1;
        end else begin
          state_s = EMPTY;
        end
      end
      ONE: begin
        if (in_beat_s && out_beat_s) begin
          state_s        = ONE;
          load_main_in_s = 1'b1;
        end else if (in_beat_s) begin
          state_s     = TWO;
          load_skid_s = 1'b1;
        end else if (out_beat_s) begin
          state_s = EMPTY;
        end else begin
          state_s = ONE;
        end
      end
      TWO: begin
        // ready is low in TWO, so only the drain transition is possible here
        if (out_beat_s) begin
          state_s          = ONE;
          load_main_skid_s = 1'b1;
        end else begin
          state_s = TWO;
        end
      end
      default: begin
        state_s = EMPTY;
      end
    endcase
  end

  // State, handshake flags and payload registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= EMPTY;
      ready_r <= 1'b0;
      valid_r <= 1'b0;
      main_r  <= {WIDTH{1'b0}};
      skid_r  <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      ready_r <= (state_s != TWO);
      valid_r <= (state_s != EMPTY);
      if (load_main_in_s) begin
        main_r <= in_data;
      end else if (load_main_skid_s) begin
        main_r <= skid_r;
      end
      if (load_skid_s) begin
        skid_r <= in_data;
      end
    end
  end

  assign in_ready  = ready_r;
  assign out_data  = main_r;
  assign out_valid = valid_r;

endmodule

// File: rtl/conware_frame_stats.sv
// Forwards the Game-of-Life board stream and reports per-generation population
// and frame-length status. Optional generation counter: CONWARE_FRAME_STATS_GEN_COUNT_EN.
module conware_frame_stats
  import conware_pkg::*;
#(
  parameter int DATA_WIDTH      = CONWARE_DATA_WIDTH,
  parameter int WORDS_PER_FRAME = CONWARE_WORDS_PER_FRAME,
  parameter int POP_WIDTH       = CONWARE_POP_WIDTH
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  conware_frame_stats_if.slave  s_axis,
  conware_frame_stats_if.master m_axis,
  output logic [POP_WIDTH-1:0]  POP_COUNT,
  output logic                  FRAME_DONE,
  output logic                  LEN_ERR
`ifdef CONWARE_FRAME_STATS_GEN_COUNT_EN
  ,
  output logic [15:0]           GEN_COUNT,
  output logic [7:0]            GEN_LED
`endif
);

  localparam int IDX_W = $clog2(WORDS_PER_FRAME + 1);
  localparam logic [IDX_W:0] WPF_C = (IDX_W + 1)'(WORDS_PER_FRAME);

  logic [DATA_WIDTH:0]         in_payload_s;
  logic [DATA_WIDTH:0]         out_payload_s;
  logic                        s_ready_s;
  logic                        m_valid_s;
  logic                        in_beat_s;
  logic [CONWARE_DATA_WIDTH-1:0] pc_word_s;
  logic [POP_WIDTH-1:0]        pc_s;
  logic [POP_WIDTH-1:0]        sum_s;
  logic [IDX_W:0]              idx_inc_s;
  logic                        idx_full_s;
  logic                        len_err_s;
  logic [POP_WIDTH-1:0]        acc_r;
  logic [IDX_W-1:0]            idx_r;
  logic [POP_WIDTH-1:0]        pop_count_r;
  logic                        frame_done_r;
  logic                        len_err_r;

  assign in_payload_s = {s_axis.TDATA, s_axis.TLAST};

  conware_axis_skid #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_skid (
    .clk       (ACLK),
    .rst       (ARESET),
    .in_data   (in_payload_s),
    .in_valid  (s_axis.TVALID),
    .in_ready  (s_ready_s),
    .out_data  (out_payload_s),
    .out_valid (m_valid_s),
    .out_ready (m_axis.TREADY)
  );

  assign s_axis.TREADY = s_ready_s;
  assign m_axis.TVALID = m_valid_s;
  assign m_axis.TDATA  = out_payload_s[DATA_WIDTH:1];
  assign m_axis.TLAST  = out_payload_s[0];
  assign m_axis.TKEEP  = {(DATA_WIDTH/8){1'b1}};
  assign m_axis.TSTRB  = {(DATA_WIDTH/8){1'b1}};

  assign in_beat_s = s_axis.TVALID & s_ready_s;

  // Zero-extend the incoming word to the shared popcount width.
  always_comb begin
    pc_word_s                 = {CONWARE_DATA_WIDTH{1'b0}};
    pc_word_s[DATA_WIDTH-1:0] = s_axis.TDATA;
  end

  assign pc_s       = POP_WIDTH'(popcount(pc_word_s));
  assign sum_s      = acc_r + pc_s;
  assign idx_inc_s  = {1'b0, idx_r} + {{IDX_W{1'b0}}, 1'b1};
  assign idx_full_s = ({1'b0, idx_r} == WPF_C);
  // a saturated index gives idx+1 = WORDS_PER_FRAME+1, so the length error follows naturally
  assign len_err_s  = (idx_inc_s != WPF_C);

  // Per-generation accumulation and status update on accepted input beats.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      acc_r        <= {POP_WIDTH{1'b0}};
      idx_r        <= {IDX_W{1'b0}};
      pop_count_r  <= {POP_WIDTH{1'b0}};
      frame_done_r <= 1'b0;
      len_err_r    <= 1'b0;
    end else begin
      frame_done_r <= in_beat_s & s_axis.TLAST;
      if (in_beat_s) begin
        if (s_axis.TLAST) begin
          pop_count_r <= sum_s;
          len_err_r   <= len_err_s;
          acc_r       <= {POP_WIDTH{1'b0}};
          idx_r       <= {IDX_W{1'b0}};
        end else begin
          acc_r <= sum_s;
          if (!idx_full_s) begin
            idx_r <= idx_inc_s[IDX_W-1:0];
          end
        end
      end
    end
  end

  assign POP_COUNT  = pop_count_r;
  assign FRAME_DONE = frame_done_r;
  assign LEN_ERR    = len_err_r;

`ifdef CONWARE_FRAME_STATS_GEN_COUNT_EN
  logic [15:0] gen_count_r;

  // Generation counter, advancing together with POP_COUNT.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      gen_count_r <= 16'd0;
    end else if (in_beat_s && s_axis.TLAST) begin
      gen_count_r <= gen_count_r + 16'd1;
    end
  end

  assign GEN_COUNT = gen_count_r;
  assign GEN_LED   = gen_count_r[7:0];
`endif

endmodule

// File: tb/tb_conware_frame_stats.sv
// Directed self-checking bench for conware_frame_stats.
module tb_conware_frame_stats;
  import conware_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [10:0] pop;
  logic        fd;
  logic        le;
`ifdef CONWARE_FRAME_STATS_GEN_COUNT_EN
  logic [15:0] gen;
  logic [7:0]  led;
`endif

  always #5 ACLK = ~ACLK;

  conware_frame_stats_if #(.DATA_WIDTH(32)) s_if ();
  conware_frame_stats_if #(.DATA_WIDTH(32)) m_if ();

  conware_frame_stats dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .s_axis     (s_if),
    .m_axis     (m_if),
    .POP_COUNT  (pop),
    .FRAME_DONE (fd),
    .LEN_ERR    (le)
`ifdef CONWARE_FRAME_STATS_GEN_COUNT_EN
    ,
    .GEN_COUNT  (gen),
    .GEN_LED    (led)
`endif
  );

  int          tests = 0;
  int          fails = 0;
  int          mode = 0;       // 0 sink ready, 1 sink toggling, 2 sink stalled
  int          comb_viol = 0;
  int          fd_cnt = 0;
  int          out_cnt = 0;
  logic        tog = 1'b0;
  logic        tr_before;
  logic [32:0] exp_q[$];
  logic [32:0] exp_w;
  logic        has_w;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Offers one beat and waits (bounded) until it is accepted.
  task automatic send(input logic [31:0] d, input logic l);
    int n;
    s_if.TVALID = 1'b1;
    s_if.TDATA  = d;
    s_if.TLAST  = l;
    n = 0;
    while (!s_if.TREADY && n < 50) begin
      tick();
      n++;
    end
    if (!s_if.TREADY) chk("send_timeout", {31'd0, s_if.TREADY}, 32'd1);
    tick();
    s_if.TVALID = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_if.TVALID) && n < 100) begin
      tick();
      n++;
    end
    chk("drain", {31'd0, (n < 100)}, 32'd1);
  endtask

  // Sink ready pattern; also confirms upstream ready does not react within the cycle.
  always @(posedge ACLK) begin
    #3;
    tr_before = s_if.TREADY;
    case (mode)
      0: m_if.TREADY = 1'b1;
      1: begin
        tog = ~tog;
        m_if.TREADY = tog;
      end
      default: m_if.TREADY = 1'b0;
    endcase
    #1;
    if (s_if.TREADY !== tr_before) comb_viol++;
  end

  // Scoreboard: accepted input beats must come out in order, once each.
  always @(negedge ACLK) begin
    if (ARESET) begin
      exp_q.delete();
    end else begin
      if (m_if.TVALID && m_if.TREADY) begin
        out_cnt++;
        has_w = (exp_q.size() > 0);
        exp_w = has_w ? exp_q.pop_front() : 33'd0;
        tests++;
        assert (has_w && ({m_if.TDATA, m_if.TLAST} === exp_w)) else begin
          fails++;
          $error("FAIL out_beat: observed 0x%0h expected 0x%0h (pending %0d)",
                 {m_if.TDATA, m_if.TLAST}, exp_w, has_w);
        end
      end
      if (s_if.TVALID && s_if.TREADY) exp_q.push_back({s_if.TDATA, s_if.TLAST});
      if (fd) fd_cnt++;
    end
  end

  initial begin
    int fd0;
    int oc0;
    ARESET      = 1'b1;
    s_if.TVALID = 1'b0;
    s_if.TDATA  = 32'd0;
    s_if.TLAST  = 1'b0;
    m_if.TREADY = 1'b1;
    tick();
    tick();
    chk("rst_m_valid", {31'd0, m_if.TVALID}, 32'd0);
    chk("rst_m_data", m_if.TDATA, 32'd0);
    chk("rst_m_last", {31'd0, m_if.TLAST}, 32'd0);
    chk("rst_s_ready", {31'd0, s_if.TREADY}, 32'd0);
    chk("rst_pop", {21'd0, pop}, 32'd0);
    chk("rst_fd", {31'd0, fd}, 32'd0);
    chk("rst_lenerr", {31'd0, le}, 32'd0);
    chk("tkeep", {28'd0, m_if.TKEEP}, 32'hF);
    chk("tstrb", {28'd0, m_if.TSTRB}, 32'hF);
    ARESET = 1'b0;
    tick();
    chk("s_ready_after_rst", {31'd0, s_if.TREADY}, 32'd1);

    // Full board, sink always ready: one-cycle mirror, population 1024
    fd0 = fd_cnt;
    for (int k = 0; k < 32; k++) begin
      send(32'hFFFF_FFFF, (k == 31));
      chk("mirror_valid", {31'd0, m_if.TVALID}, 32'd1);
      chk("mirror_data", m_if.TDATA, 32'hFFFF_FFFF);
      chk("mirror_last", {31'd0, m_if.TLAST}, (k == 31) ? 32'd1 : 32'd0);
    end
    chk("full_fd", {31'd0, fd}, 32'd1);
    chk("full_pop", {21'd0, pop}, 32'd1024);
    chk("full_lenerr", {31'd0, le}, 32'd0);
    tick();
    tick();
    chk("full_fd_once", fd_cnt - fd0, 32'd1);
    drain();

    // One-hot words with a toggling sink
    mode = 1;
    oc0  = out_cnt;
    comb_viol = 0;
    for (int k = 0; k < 32; k++) begin
      send(32'd1 << k, (k == 31));
    end
    chk("onehot_pop", {21'd0, pop}, 32'd32);
    chk("onehot_lenerr", {31'd0, le}, 32'd0);
    drain();
    chk("onehot_out_count", out_cnt - oc0, 32'd32);
    chk("ready_no_comb", comb_viol, 32'd0);
    mode = 0;
    tick();

    // Short (21) and long (41) frames flag a length error, 32 clears it
    for (int k = 0; k < 21; k++) send(32'd0, (k == 20));
    chk("short_pop", {21'd0, pop}, 32'd0);
    chk("short_lenerr", {31'd0, le}, 32'd1);
    for (int k = 0; k < 41; k++) send(32'd0, (k == 40));
    chk("long_pop", {21'd0, pop}, 32'd0);
    chk("long_lenerr", {31'd0, le}, 32'd1);
    for (int k = 0; k < 32; k++) send(32'd1, (k == 31));
    chk("exact_pop", {21'd0, pop}, 32'd32);
    chk("exact_lenerr", {31'd0, le}, 32'd0);

    // Back-to-back frames, populations 5 and 7
    tick();
    tick();
    fd0 = fd_cnt;
    for (int k = 0; k < 32; k++) send((k == 0) ? 32'h1F : 32'd0, (k == 31));
    chk("b2b_pop5", {21'd0, pop}, 32'd5);
    for (int k = 0; k < 32; k++) send((k == 31) ? 32'h7F : 32'd0, (k == 31));
    chk("b2b_pop7", {21'd0, pop}, 32'd7);
    chk("b2b_lenerr", {31'd0, le}, 32'd0);
    tick();
    tick();
    chk("b2b_fd_count", fd_cnt - fd0, 32'd2);
    drain();

    // Reset mid-frame with the sink stalled
    for (int k = 0; k < 10; k++) send(32'hFFFF_FFFF, 1'b0);
    mode = 2;
    s_if.TVALID = 1'b1;
    s_if.TDATA  = 32'hFFFF_FFFF;
    s_if.TLAST  = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("stall_s_ready", {31'd0, s_if.TREADY}, 32'd0);
    chk("stall_m_valid", {31'd0, m_if.TVALID}, 32'd1);
    s_if.TVALID = 1'b0;
    ARESET = 1'b1;
    tick();
    chk("mid_rst_m_valid", {31'd0, m_if.TVALID}, 32'd0);
    chk("mid_rst_m_data", m_if.TDATA, 32'd0);
    chk("mid_rst_m_last", {31'd0, m_if.TLAST}, 32'd0);
    chk("mid_rst_s_ready", {31'd0, s_if.TREADY}, 32'd0);
    chk("mid_rst_pop", {21'd0, pop}, 32'd0);
    chk("mid_rst_fd", {31'd0, fd}, 32'd0);
    chk("mid_rst_lenerr", {31'd0, le}, 32'd0);
    ARESET = 1'b0;
    mode = 0;
    tick();
    chk("post_rst_s_ready", {31'd0, s_if.TREADY}, 32'd1);
    chk("post_rst_m_valid", {31'd0, m_if.TVALID}, 32'd0);
    for (int k = 0; k < 32; k++) send(32'h3, (k == 31));
    chk("post_rst_pop", {21'd0, pop}, 32'd64);
    chk("post_rst_lenerr", {31'd0, le}, 32'd0);

    // Single-beat frames
    send(32'hF0F0_F0F0, 1'b1);
    chk("single_pop", {21'd0, pop}, 32'd16);
    chk("single_lenerr", {31'd0, le}, 32'd1);
    send(32'h8000_0001, 1'b1);
    chk("single2_pop", {21'd0, pop}, 32'd2);
    chk("single2_lenerr", {31'd0, le}, 32'd1);
    drain();
`ifdef CONWARE_FRAME_STATS_GEN_COUNT_EN
    chk("gen_count", {16'd0, gen}, 32'd3);
    chk("gen_led", {24'd0, led}, 32'h03);
`endif
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
